// File: rtl/uart_pkg.sv
// Shared definitions for the APB UART receive slave.
//   - register word addresses decoded from paddr
//   - bit positions inside the STATUS register
//   - receiver and APB completer state encodings
package uart_pkg;

  localparam logic [4:0] ADDR_RXDATA = 5'd0;
  localparam logic [4:0] ADDR_STATUS = 5'd1;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_CNT_LSB   = 2;
  localparam int ST_CNT_MSB   = 5;
  localparam int ST_OVERRUN   = 6;
  localparam int ST_FRAME_ERR = 7;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
  typedef enum logic [1:0] {ARM, WAIT, DONE} apb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO.
//   clk, srst : clock and synchronous active-high reset
//   push, din : write request and data (ignored when full unless popping too)
//   pop       : read request (ignored when empty)
//   dout      : head entry, valid whenever empty = 0
//   empty, full, count : occupancy, count ranges 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/apb_uart_rx_slave.sv
// APB completer receiving 8N1 UART frames into an RX FIFO.
//   pclk, Reset          : clock, synchronous active-high reset
//   psel, penable,
//   pwrite, paddr        : APB request (word 0 RXDATA pop, word 1 STATUS)
//   prdata, pready,
//   pslverr              : registered APB completion
//   rx                   : asynchronous serial input, idle high, LSB first
module apb_uart_rx_slave
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 8,
  parameter int TIMEOUT      = 16
) (
  input  logic        pclk,
  input  logic        Reset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [4:0]  paddr,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        rx
);

  localparam int CLK_W = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CLK_W-1:0] HALF_LAST = CLK_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CLK_W-1:0] BIT_LAST  = CLK_W'(CLKS_PER_BIT - 1);

  // Receiver state
  rx_state_e        rx_state_q, rx_state_d;
  logic [CLK_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             rx_meta_q, rx_sync_q;
  logic             stop_ok, stop_bad;

  // APB state
  apb_state_e       apb_state_q, apb_state_d;
  logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0]      prdata_q, prdata_d;
  logic             pready_q, pready_d, pslverr_q, pslverr_d;
  logic             overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic             sticky_clr;

  // FIFO interface
  logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       status;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (pclk),
    .srst  (Reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (shift_q),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Receiver: samples are taken mid-bit, so the stop-bit decision lands in
  // the middle of the stop bit and the FSM is idle before the next start edge.
  always_comb begin
    rx_state_d = rx_state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (rx_state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = START;
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
        end
      end
      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d  = '0;
          rx_state_d = rx_sync_q ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) rx_state_d = STOP;
          else                   bit_cnt_d  = bit_cnt_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d  = '0;
          rx_state_d = IDLE;
          stop_ok    = rx_sync_q;
          stop_bad   = !rx_sync_q;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  assign fifo_push = stop_ok && (!fifo_full || fifo_pop);

  always_comb begin
    status                        = '0;
    status[ST_EMPTY]              = fifo_empty;
    status[ST_FULL]               = fifo_full;
    status[ST_CNT_MSB:ST_CNT_LSB] = 4'(fifo_count);
    status[ST_OVERRUN]            = overrun_q;
    status[ST_FRAME_ERR]          = frame_err_q;
  end

  // APB completer: every decision is registered, giving at least one wait state.
  always_comb begin
    apb_state_d = apb_state_q;
    wait_cnt_d  = wait_cnt_q;
    prdata_d    = prdata_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    fifo_pop    = 1'b0;
    sticky_clr  = 1'b0;
    case (apb_state_q)
      ARM: begin
        wait_cnt_d = '0;
        if (psel && !penable) apb_state_d = WAIT;
      end
      WAIT: begin
        if (!(psel && penable)) begin
          // Master gave up; a fresh setup cycle re-arms immediately.
          wait_cnt_d  = '0;
          apb_state_d = (psel && !penable) ? WAIT : ARM;
        end else if (pwrite || (paddr != ADDR_RXDATA && paddr != ADDR_STATUS)) begin
          prdata_d    = '0;
          pready_d    = 1'b1;
          pslverr_d   = 1'b1;
          apb_state_d = DONE;
        end else if (paddr == ADDR_STATUS) begin
          // Clearing at the capture edge means any event arriving in this
          // same cycle re-sets its flag and is never lost.
          prdata_d    = {24'b0, status};
          pready_d    = 1'b1;
          sticky_clr  = 1'b1;
          apb_state_d = DONE;
        end else if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          prdata_d    = {24'b0, fifo_dout};
          pready_d    = 1'b1;
          apb_state_d = DONE;
        end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
          prdata_d    = '0;
          pready_d    = 1'b1;
          pslverr_d   = 1'b1;
          apb_state_d = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      DONE: begin
        wait_cnt_d  = '0;
        apb_state_d = ARM;
      end
      default: apb_state_d = ARM;
    endcase
  end

  // A push is lost only when the FIFO stays full through the stop-bit cycle.
  assign overrun_d   = (stop_ok && fifo_full && !fifo_pop) || (overrun_q && !sticky_clr);
  assign frame_err_d = stop_bad || (frame_err_q && !sticky_clr);

  always_ff @(posedge pclk) begin
    if (Reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      apb_state_q <= ARM;
      wait_cnt_q  <= '0;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      apb_state_q <= apb_state_d;
      wait_cnt_q  <= wait_cnt_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_uart_rx_slave.sv
module tb_apb_uart_rx_slave;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam int TO    = 16;

  logic        pclk = 1'b0;
  logic        Reset, psel, penable, pwrite, rx;
  logic [4:0]  paddr;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents as a queue plus the two sticky flags.
  byte unsigned model_q[$];
  bit           model_ovr, model_fe;

  always #5 pclk = ~pclk;

  apb_uart_rx_slave #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .pclk(pclk), .Reset(Reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .prdata(prdata), .pready(pready), .pslverr(pslverr), .rx(rx)
  );

  function automatic logic [31:0] model_status();
    logic [7:0] s;
    s = 8'h00;
    if (model_q.size() == 0)     s = s | 8'h01;
    if (model_q.size() == DEPTH) s = s | 8'h02;
    s = s + 8'(model_q.size() * 4);
    if (model_ovr) s = s | 8'h40;
    if (model_fe)  s = s | 8'h80;
    return {24'b0, s};
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(posedge pclk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_frame(b, stop_bit);
    if (!stop_bit)                    model_fe  = 1'b1;
    else if (model_q.size() < DEPTH)  model_q.push_back(b);
    else                              model_ovr = 1'b1;
    $display("frame  byte=0x%02h stop=%0d model_count=%0d", b, stop_bit, model_q.size());
  endtask

  task automatic apb_xfer(input bit wr, input logic [4:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int waits,
                          output logic rdy_after);
    bit done;
    done = 1'b0;
    waits = 0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int n = 1; n <= 200 && !done; n++) begin
      @(posedge pclk); #1;
      if (pready === 1'b1) begin
        done  = 1'b1;
        waits = n;
      end
    end
    rd  = prdata;
    err = pslverr;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL apb_timeout addr=%0d: pready never rose within 200 cycles", a);
    end
    @(posedge pclk); #1;
    rdy_after = pready;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    $display("apb    %s addr=%0d wdata=0x%08h rdata=0x%08h err=%0d waits=%0d",
             wr ? "wr" : "rd", a, wd, rd, err, waits);
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err, ra; int w;
    Reset = 1'b1; rx = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 5'd0;
    idle(5);
    Reset = 1'b0;
    // Abort a frame in progress: partial byte must never appear.
    rx = 1'b0;
    idle(3 * CPB);
    Reset = 1'b1;
    idle(3);
    n_checks++; if (pready !== 1'b0)   begin n_fail++; $display("FAIL reset_pready got=%b want=0", pready); end
    n_checks++; if (pslverr !== 1'b0)  begin n_fail++; $display("FAIL reset_pslverr got=%b want=0", pslverr); end
    n_checks++; if (prdata !== 32'h0)  begin n_fail++; $display("FAIL reset_prdata got=0x%08h want=0", prdata); end
    rx = 1'b1;
    Reset = 1'b0;
    idle(12 * CPB);
    // Empty RXDATA read runs to the timeout.
    apb_xfer(1'b0, 5'd0, 32'h0, rd, err, w, ra);
    n_checks++; if (w !== TO)        begin n_fail++; $display("FAIL empty_read_waits got=%0d want=%0d", w, TO); end
    n_checks++; if (err !== 1'b1)    begin n_fail++; $display("FAIL empty_read_err got=%b want=1", err); end
    n_checks++; if (rd !== 32'h0)    begin n_fail++; $display("FAIL empty_read_data got=0x%08h want=0", rd); end
    n_checks++; if (ra !== 1'b0)     begin n_fail++; $display("FAIL empty_read_pready_len got=%b want=0", ra); end
    apb_xfer(1'b0, 5'd1, 32'h0, rd, err, w, ra);
    n_checks++; if (rd !== 32'h1)    begin n_fail++; $display("FAIL reset_status got=0x%08h want=0x00000001", rd); end
  endtask

  task automatic test_single();
    logic [31:0] rd, exp; logic err, ra; int w;
    send_frame(8'h55, 1'b1);
    idle(4);
    apb_xfer(1'b0, 5'd1, 32'h0, rd, err, w, ra);
    exp = model_status(); model_ovr = 0; model_fe = 0;
    n_checks++; if (rd !== exp || rd !== 32'h04) begin n_fail++; $display("FAIL single_status got=0x%08h want=0x%08h", rd, exp); end
    apb_xfer(1'b0, 5'd0, 32'h0, rd, err, w, ra);
    exp = {24'b0, model_q.pop_front()};
    n_checks++; if (rd !== exp)   begin n_fail++; $display("FAIL single_data got=0x%08h want=0x%08h", rd, exp); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err got=%b want=0", err); end
    n_checks++; if (w !== 1)      begin n_fail++; $display("FAIL single_waits got=%0d want=1", w); end
    n_checks++; if (ra !== 1'b0)  begin n_fail++; $display("FAIL single_pready_len got=%b want=0", ra); end
    apb_xfer(1'b0, 5'd1, 32'h0, rd, err, w, ra);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL single_status_after got=0x%08h want=0x00000001", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, exp; logic err, ra; int w;
    send_frame(8'h55, 1'b1);
    send_frame(8'hCC, 1'b1);
    idle(2);
    for (int i = 0; i < 2; i++) begin
      apb_xfer(1'b0, 5'd0, 32'h0, rd, err, w, ra);
      exp = {24'b0, model_q.pop_front()};
      n_checks++; if (rd !== exp || err !== 1'b0) begin n_fail++; $display("FAIL b2b_data[%0d] got=0x%08h err=%b want=0x%08h err=0", i, rd, err, exp); end
    end
  endtask

  task automatic test_overrun();
    logic [31:0] rd, exp; logic err, ra; int w;
    for (int i = 0; i < DEPTH + 1; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    idle(2);
    apb_xfer(1'b0, 5'd1, 32'h0, rd, err, w, ra);
    exp = model_status(); model_ovr = 0; model_fe = 0;
    n_checks++; if (rd !== exp || rd !== 32'h62) begin n_fail++; $display("FAIL overrun_status got=0x%08h want=0x%08h", rd, exp); end
    for (int i = 0; i < DEPTH; i++) begin
      apb_xfer(1'b0, 5'd0, 32'h0, rd, err, w, ra);
      exp = {24'b0, model_q.pop_front()};
      n_checks++; if (rd !== exp || err !== 1'b0) begin n_fail++; $display("FAIL overrun_data[%0d] got=0x%08h want=0x%08h", i, rd, exp); end
    end
    apb_xfer(1'b0, 5'd1, 32'h0, rd, err, w, ra);
    exp = model_status();
    n_checks++; if (rd !== exp || rd[6] !== 1'b0) begin n_fail++; $display("FAIL overrun_cleared got=0x%08h want=0x%08h", rd, exp); end
  endtask

  task automatic test_frame_err();
    logic [31:0] rd, exp; logic err, ra; int w;
    logic [7:0] b;
    send_frame(8'($urandom_range(0, 255)), 1'b0);
    idle(2 * CPB);
    apb_xfer(1'b0, 5'd1, 32'h0, rd, err, w, ra);
    exp = model_status(); model_ovr = 0; model_fe = 0;
    n_checks++; if (rd !== exp || rd !== 32'h81) begin n_fail++; $display("FAIL frame_err_status got=0x%08h want=0x%08h", rd, exp); end
    rx = 1'b0; idle(4); rx = 1'b1;
    idle(3 * CPB);
    apb_xfer(1'b0, 5'd1, 32'h0, rd, err, w, ra);
    exp = model_status();
    n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL glitch_status got=0x%08h want=0x%08h", rd, exp); end
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1);
    apb_xfer(1'b0, 5'd0, 32'h0, rd, err, w, ra);
    exp = {24'b0, model_q.pop_front()};
    n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL after_glitch_data got=0x%08h want=0x%08h", rd, exp); end
  endtask

  task automatic test_bad_access();
    logic [31:0] rd, exp; logic err, ra; int w;
    logic [4:0] a;
    send_frame(8'($urandom_range(0, 255)), 1'b1);
    apb_xfer(1'b1, 5'd0, 32'hABCD1234, rd, err, w, ra);
    n_checks++; if (err !== 1'b1 || w !== 1) begin n_fail++; $display("FAIL write_err got err=%b waits=%0d want err=1 waits=1", err, w); end
    apb_xfer(1'b0, 5'd3, 32'h0, rd, err, w, ra);
    n_checks++; if (err !== 1'b1 || w !== 1) begin n_fail++; $display("FAIL unmapped_err got err=%b waits=%0d want err=1 waits=1", err, w); end
    for (int i = 0; i < 4; i++) begin
      a = 5'($urandom_range(2, 31));
      apb_xfer(1'($urandom_range(0, 1)), a, $urandom, rd, err, w, ra);
      n_checks++; if (err !== 1'b1 || w !== 1) begin n_fail++; $display("FAIL rand_unmapped addr=%0d got err=%b waits=%0d want err=1 waits=1", a, err, w); end
    end
    apb_xfer(1'b0, 5'd1, 32'h0, rd, err, w, ra);
    exp = model_status(); model_ovr = 0; model_fe = 0;
    n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL bad_access_status got=0x%08h want=0x%08h", rd, exp); end
    apb_xfer(1'b0, 5'd0, 32'h0, rd, err, w, ra);
    exp = {24'b0, model_q.pop_front()};
    n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL bad_access_data got=0x%08h want=0x%08h", rd, exp); end
  endtask

  task automatic test_stall();
    logic [31:0] rd, exp; logic err, ra; int w;
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    exp = {24'b0, b};
    // The byte lands roughly ten cycles into the read's wait phase.
    fork
      drive_frame(b, 1'b1);
      begin
        idle(145);
        apb_xfer(1'b0, 5'd0, 32'h0, rd, err, w, ra);
      end
    join
    n_checks++; if (rd !== exp || err !== 1'b0) begin n_fail++; $display("FAIL stall_data got=0x%08h err=%b want=0x%08h err=0", rd, err, exp); end
    n_checks++; if (w < 2 || w >= TO) begin n_fail++; $display("FAIL stall_waits got=%0d want 2..%0d", w, TO - 1); end
    apb_xfer(1'b0, 5'd1, 32'h0, rd, err, w, ra);
    exp = model_status();
    n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL stall_status got=0x%08h want=0x%08h", rd, exp); end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp; logic err, ra; int w, k;
    for (int r = 0; r < 5; r++) begin
      k = $urandom_range(1, 3);
      for (int i = 0; i < k; i++) send_frame(8'($urandom), 1'b1);
      idle($urandom_range(1, 20));
      apb_xfer(1'b0, 5'd1, 32'h0, rd, err, w, ra);
      exp = model_status(); model_ovr = 0; model_fe = 0;
      n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL rand_status[%0d] got=0x%08h want=0x%08h", r, rd, exp); end
      while (model_q.size() > 0) begin
        apb_xfer(1'b0, 5'd0, 32'h0, rd, err, w, ra);
        exp = {24'b0, model_q.pop_front()};
        n_checks++; if (rd !== exp || err !== 1'b0 || w !== 1) begin n_fail++; $display("FAIL rand_data[%0d] got=0x%08h err=%b waits=%0d want=0x%08h", r, rd, err, w, exp); end
      end
    end
  endtask

  initial begin
    model_ovr = 1'b0;
    model_fe  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_bad_access();
    test_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
